// File: rtl/disp_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_rx_pkg                                                                |
// | Shared types and segment table for the serial display link receiver.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package disp_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rx_state_e;

  // Segment bit positions within a digit byte: {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG7_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage
`default_nettype wire

// File: rtl/disp_serial_rx_seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_decode                                                                |
// | Maps one 8-bit segment pattern back to a hex nibble; flags unknown shapes. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg7_decode
  import disp_rx_pkg::*;
#(
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic [7:0] seg_in,
  output logic [3:0] nibble,
  output logic       invalid
);

  logic [6:0] segs;
  logic       unused_dp;

  assign unused_dp = seg_in[SEG_DP];

  always_comb begin
    segs    = SEG_ACT_LOW ? ~seg_in[SEG_G:SEG_A] : seg_in[SEG_G:SEG_A];
    nibble  = 4'h0;
    invalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (segs == SEG7_HEX[i]) begin
        nibble  = 4'(i);
        invalid = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/disp_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_serial_rx                                                             |
// | Oversampling receiver for the ser_clk/ser_do/ser_le display link; rebuilds |
// | latched frames. Optional hex decode under DISP_RX_DECODE_EN.               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module disp_serial_rx
  import disp_rx_pkg::*;
#(
  parameter int FRAME_BITS  = 64,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ser_clk,
  input  logic                  ser_do,
  input  logic                  ser_le,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_vld,
  output logic                  frame_err,
  output logic [7:0]            bit_cnt,
  output logic [31:0]           hex_data,
  output logic                  hex_err
);

  localparam int            TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // Synchronizer bit order: {le, do, clk}
  logic [2:0] sync1_d, sync1_q, sync2_d, sync2_q;
  logic [1:0] prev_d, prev_q;
  logic       clk_rise, clk_fall, le_rise, din;

  rx_state_e              state_d, state_q;
  logic [FRAME_BITS-1:0]  shreg_d, shreg_q, shifted;
  logic [FRAME_BITS-1:0]  frame_d, frame_q;
  logic [7:0]             cnt_d, cnt_q;
  logic [TO_W-1:0]        to_cnt_d, to_cnt_q;
  logic                   vld_d, vld_q, err_d, err_q;
  logic                   hex_load;

  assign sync1_d  = {ser_le, ser_do, ser_clk};
  assign sync2_d  = sync1_q;
  assign prev_d   = {sync2_q[2], sync2_q[0]};
  assign clk_rise = sync2_q[0] & ~prev_q[0];
  assign clk_fall = ~sync2_q[0] & prev_q[0];
  assign le_rise  = sync2_q[2] & ~prev_q[1];
  assign din      = sync2_q[1];
  assign shifted  = MSB_FIRST ? {shreg_q[FRAME_BITS-2:0], din}
                              : {din, shreg_q[FRAME_BITS-1:1]};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    frame_d  = frame_q;
    cnt_d    = cnt_q;
    to_cnt_d = to_cnt_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    hex_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (clk_rise) begin
          shreg_d = shifted;
          cnt_d   = 8'd1;
          state_d = le_rise ? ST_DONE : ST_SHIFT;
        end else if (le_rise) begin
          err_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (clk_rise) begin
          shreg_d = shifted;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
        to_cnt_d = (clk_rise | clk_fall) ? '0 : to_cnt_q + 1'b1;
        // The shift above still counts when the latch arrives in the same cycle
        if (le_rise) begin
          state_d = ST_DONE;
        end else if (!clk_rise && !clk_fall && to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (cnt_q == 8'(FRAME_BITS)) begin
          frame_d  = shreg_q;
          vld_d    = 1'b1;
          hex_load = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        cnt_d   = 8'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      frame_q  <= '0;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
    end
  end

  assign frame     = frame_q;
  assign frame_vld = vld_q;
  assign frame_err = err_q;
  assign bit_cnt   = cnt_q;

`ifdef DISP_RX_DECODE_EN
  logic [31:0] dec_nib, hex_d, hex_q;
  logic [7:0]  dec_inv;
  logic        hex_err_d, hex_err_q;

  for (genvar g = 0; g < 8; g++) begin : g_digit
    seg7_decode #(
      .SEG_ACT_LOW (SEG_ACT_LOW)
    ) u_dec (
      .seg_in  (shreg_q[8*g +: 8]),
      .nibble  (dec_nib[4*g +: 4]),
      .invalid (dec_inv[g])
    );
  end

  always_comb begin
    hex_d     = hex_q;
    hex_err_d = hex_err_q;
    if (hex_load) begin
      hex_d     = dec_nib;
      hex_err_d = |dec_inv;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hex_q     <= '0;
      hex_err_q <= 1'b0;
    end else begin
      hex_q     <= hex_d;
      hex_err_q <= hex_err_d;
    end
  end

  assign hex_data = hex_q;
  assign hex_err  = hex_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = hex_load ^ SEG_ACT_LOW;
  assign hex_data   = 32'h0;
  assign hex_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_disp_serial_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_disp_serial_rx                                                          |
// | Randomized bench for disp_serial_rx against a frame-level reference model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_disp_serial_rx;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        ser_clk = 1'b0, ser_do = 1'b0, ser_le = 1'b0;
  logic [63:0] frame;
  logic        frame_vld, frame_err;
  logic [7:0]  bit_cnt;
  logic [31:0] hex_data;
  logic        hex_err;

  always #20 clk = ~clk;

  disp_serial_rx u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .ser_clk   (ser_clk),
    .ser_do    (ser_do),
    .ser_le    (ser_le),
    .frame     (frame),
    .frame_vld (frame_vld),
    .frame_err (frame_err),
    .bit_cnt   (bit_cnt),
    .hex_data  (hex_data),
    .hex_err   (hex_err)
  );

  typedef struct packed {
    logic        is_vld;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] m_sh     = '0;
  logic [63:0] m_frame  = '0;
  int          m_cnt    = 0;
  logic [31:0] m_hex    = '0;
  logic        m_hex_err = 1'b0;
  bit          mon_en   = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Wire bytes are active-low; digit d sits in frame[8d+7:8d]
  function automatic void decode_frame(input logic [63:0] f, output logic [31:0] h,
                                       output logic e);
    logic [7:0] b;
    logic       hit;
    h = '0;
    e = 1'b0;
    for (int d = 0; d < 8; d++) begin
      b   = ~f[8*d +: 8];
      hit = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!hit && b[6:0] == seg_tab[k]) begin
          h[4*d +: 4] = 4'(k);
          hit = 1'b1;
        end
      end
      if (!hit) e = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_vld || frame_err) begin
        check("vld_err_excl", {63'd0, frame_vld & frame_err}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {62'd0, frame_vld, frame_err}, 64'd0);
        end else begin
          cur_e = exp_q.pop_front();
          check("pulse_kind", {63'd0, frame_vld}, {63'd0, cur_e.is_vld});
          if (cur_e.is_vld) begin
            m_frame = cur_e.data;
            decode_frame(cur_e.data, m_hex, m_hex_err);
          end
        end
      end
      check("frame", frame, m_frame);
`ifdef DISP_RX_DECODE_EN
      check("hex_data", {32'd0, hex_data}, {32'd0, m_hex});
      check("hex_err", {63'd0, hex_err}, {63'd0, m_hex_err});
`else
      check("hex_tied", {31'd0, hex_err, hex_data}, 64'd0);
`endif
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d);
    ser_do = d;
    wait_clk($urandom_range(3, 6));
    ser_clk = 1'b1;
    wait_clk($urandom_range(3, 6));
    ser_clk = 1'b0;
    wait_clk($urandom_range(3, 6));
    m_sh = {m_sh[62:0], d};
    m_cnt++;
    check("bit_cnt", {56'd0, bit_cnt}, 64'((m_cnt > 255) ? 255 : m_cnt));
  endtask

  task automatic send_word(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic drain(input int max, output int used);
    used = 0;
    while (exp_q.size() != 0 && used < max) begin
      wait_clk(1);
      used++;
    end
    wait_clk(2);
    check("pulse_seen", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic expect_latch();
    exp_t e;
    e.is_vld = (m_cnt == 64);
    e.data   = m_sh;
    exp_q.push_back(e);
    m_cnt = 0;
  endtask

  task automatic pulse_le();
    int used;
    expect_latch();
    ser_le = 1'b1;
    wait_clk($urandom_range(3, 6));
    ser_le = 1'b0;
    wait_clk(4);
    drain(30, used);
    check("bit_cnt_clear", {56'd0, bit_cnt}, 64'd0);
  endtask

  task automatic last_bit_with_le(input logic d);
    int used;
    ser_do = d;
    wait_clk(4);
    m_sh = {m_sh[62:0], d};
    m_cnt++;
    expect_latch();
    ser_clk = 1'b1;
    ser_le  = 1'b1;
    wait_clk(4);
    ser_clk = 1'b0;
    ser_le  = 1'b0;
    wait_clk(4);
    drain(30, used);
  endtask

  task automatic send_random(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  initial begin
    int          used;
    logic [63:0] w;

    #5 rstn = 1'b0;
    wait_clk(3);
    check("reset_outputs", {frame_vld, frame_err, bit_cnt, hex_err, hex_data[20:0]}, 64'd0);
    check("reset_frame", frame, 64'd0);
    rstn   = 1'b1;
    mon_en = 1'b1;
    wait_clk(3);

    send_word(64'h0123_4567_89AB_CDEF, 64);
    pulse_le();
    check("t1_frame_literal", frame, 64'h0123_4567_89AB_CDEF);

    send_random(63);
    pulse_le();
    check("t2_frame_kept", frame, 64'h0123_4567_89AB_CDEF);

    pulse_le();

    send_random(10);
    expect_latch();
    drain(4300, used);
    check("t3_timeout_window", 64'((used >= 4085) && (used <= 4110)), 64'd1);
    check("t3_bit_cnt_clear", {56'd0, bit_cnt}, 64'd0);
    send_random(64);
    pulse_le();

    send_random(63);
    last_bit_with_le(1'b1);
    send_word(64'hFEDC_BA98_7654_3210, 63);
    last_bit_with_le(1'b0);
    check("t4_frame_literal", frame, 64'hFDB9_7530_ECA8_6420);

    send_random(30);
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    check("t5_reset_outputs", {frame_vld, frame_err, bit_cnt, hex_err, hex_data[20:0]}, 64'd0);
    check("t5_reset_frame", frame, 64'd0);
    ser_do    = 1'b0;
    m_cnt     = 0;
    m_frame   = '0;
    m_hex     = '0;
    m_hex_err = 1'b0;
    exp_q.delete();
    wait_clk(2);
    rstn   = 1'b1;
    mon_en = 1'b1;
    wait_clk(3);
    send_random(64);
    pulse_le();

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0: begin send_random($urandom_range(60, 70)); pulse_le(); end
        1: begin send_random(63); last_bit_with_le(1'($urandom_range(0, 1))); end
        default: begin send_random(64); pulse_le(); end
      endcase
    end

`ifdef DISP_RX_DECODE_EN
    for (int d = 0; d < 8; d++) w[8*d +: 8] = ~{1'b0, seg_tab[d]};
    send_word(w, 64);
    pulse_le();
    check("t6_hex_literal", {32'd0, hex_data}, 64'h7654_3210);
    check("t6_hex_ok", {63'd0, hex_err}, 64'd0);
    w[8*3 +: 8] = 8'hFF;
    send_word(w, 64);
    pulse_le();
    check("t6_hex_bad", {63'd0, hex_err}, 64'd1);
`else
    w = '0;
    check("t6_hex_off", {31'd0, hex_err, hex_data}, {32'd0, w[31:0]});
`endif

    wait_clk(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
